// File: rtl/frame_pkg.sv
// Definitions shared by the frame FIFO reader and writer sides: word width,
// default frame size and the reader FSM state encoding.
package frame_pkg;
    localparam int WORD_W        = 16;
    localparam int DEF_NUM_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        LOAD,
        SEND,
        HOLD
    } state_t;
endpackage

// File: rtl/frame_checksum.sv
// 16-bit wrapping sum of the slot words of one frame. Only compiled and used
// when FRAME_READER_CHECKSUM_EN is defined.
`ifdef FRAME_READER_CHECKSUM_EN
module frame_checksum
    import frame_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_acc,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_sum
);
    logic [WORD_W-1:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_sum <= '0;
        else if (i_acc)
            r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
endmodule
`endif

// File: rtl/frame_reader.sv
// Pops one frame from the frame FIFO and serializes its slots over a
// valid/ready word stream. FRAME_READER_CHECKSUM_EN appends a sum word.
module frame_reader
    import frame_pkg::*;
#(
    parameter int NUM_WORDS   = DEF_NUM_WORDS,
    parameter int POP_HOLDOFF = 4
) (
    input  logic                          read_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          fifo_ready,
    output logic                          frame_pop,
    input  logic [WORD_W*NUM_WORDS-1:0]   frame_data_out,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(NUM_WORDS+1)-1:0] word_idx,
    output logic                          word_last,
    output logic                          busy,
    output logic [15:0]                   frames_read
);
    localparam int IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int SLOT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int HO_W   = (POP_HOLDOFF > 1) ? $clog2(POP_HOLDOFF) : 1;
`ifdef FRAME_READER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
`endif

    state_t                               r_state;
    state_t                               w_next;
    logic [NUM_WORDS-1:0][WORD_W-1:0]     r_frame;
    logic [IDX_W-1:0]                     r_idx;
    logic [HO_W-1:0]                      r_hold;
    logic [15:0]                          r_frames;
    logic                                 w_hs;
    logic                                 w_last_hs;
    logic [SLOT_W-1:0]                    w_slot;
    logic [WORD_W-1:0]                    w_slot_data;

    assign w_hs        = (r_state == SEND) && word_ready;
    assign w_last_hs   = w_hs && (r_idx == LAST_IDX);
    assign w_slot      = r_idx[SLOT_W-1:0];
    assign w_slot_data = r_frame[w_slot];

    always_ff @(posedge read_clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (enable && fifo_ready) w_next = POP;
            POP:  w_next = WAIT;
            WAIT: w_next = LOAD;
            LOAD: w_next = SEND;
            SEND: if (w_last_hs) w_next = (POP_HOLDOFF == 0) ? IDLE : HOLD;
            // fifo_ready is deliberately not looked at here: the FIFO needs
            // time to retire the popped frame before its flag is trusted.
            HOLD: if (r_hold == HO_W'(POP_HOLDOFF - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_frame  <= '0;
            r_idx    <= '0;
            r_hold   <= '0;
            r_frames <= '0;
        end else begin
            if (r_state == LOAD)
                r_frame <= frame_data_out;

            if (r_state == LOAD)
                r_idx <= '0;
            else if (w_hs)
                r_idx <= w_last_hs ? '0 : r_idx + 1'b1;

            if (r_state == HOLD)
                r_hold <= r_hold + 1'b1;
            else
                r_hold <= '0;

            if (w_last_hs)
                r_frames <= r_frames + 16'd1;
        end
    end

`ifdef FRAME_READER_CHECKSUM_EN
    logic [WORD_W-1:0] w_cks;

    frame_checksum u_cks (
        .i_clk  (read_clk),
        .i_rst  (reset),
        .i_clr  (r_state == LOAD),
        .i_acc  (w_hs && (r_idx != LAST_IDX)),
        .i_data (w_slot_data),
        .o_sum  (w_cks)
    );

    assign word_data = !word_valid ? '0 :
                       (r_idx == LAST_IDX) ? w_cks : w_slot_data;
`else
    assign word_data = word_valid ? w_slot_data : '0;
`endif

    assign frame_pop   = (r_state == POP);
    assign word_valid  = (r_state == SEND);
    assign word_idx    = r_idx;
    assign word_last   = word_valid && (r_idx == LAST_IDX);
    assign busy        = (r_state != IDLE);
    assign frames_read = r_frames;
endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: directed frames push expected words,
// a negedge monitor pops and compares on every word handshake.
module tb_frame_reader;
    localparam int NW = 8;
    localparam int HO = 4;
    localparam int IW = $clog2(NW + 1);
`ifdef FRAME_READER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif
    localparam int NWO = NW + (CKS_EN ? 1 : 0);

    logic            read_clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            fifo_ready = 1'b0;
    logic            word_ready = 1'b1;
    logic [16*NW-1:0] frame_data_out = '0;
    logic            frame_pop, word_valid, word_last, busy;
    logic [15:0]     word_data, frames_read;
    logic [IW-1:0]   word_idx;

    frame_reader #(.NUM_WORDS(NW), .POP_HOLDOFF(HO)) dut (
        .read_clk       (read_clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_ready     (fifo_ready),
        .frame_pop      (frame_pop),
        .frame_data_out (frame_data_out),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_idx       (word_idx),
        .word_last      (word_last),
        .busy           (busy),
        .frames_read    (frames_read)
    );

    always #5 read_clk = ~read_clk;

    typedef struct packed {
        logic [15:0]   data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   pop_cyc_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   pop_count = 0;
    int   first_hs = 0;
    int   last_hs = 0;
    bit   toggle_mode = 1'b0;

    always @(posedge read_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_words(input logic [15:0] w[NW], input logic [15:0] cks);
        exp_t e;
        for (int k = 0; k < NW; k++) begin
            e.data = w[k];
            e.idx  = IW'(k);
            e.last = !CKS_EN && (k == NW - 1);
            q.push_back(e);
        end
        if (CKS_EN) begin
            e.data = cks;
            e.idx  = IW'(NW);
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic pack(input logic [15:0] w[NW], output logic [16*NW-1:0] f);
        for (int k = 0; k < NW; k++) f[16*k +: 16] = w[k];
    endtask

    // Starts one frame, releases fifo_ready (and optionally enable) once the
    // pop has been seen, then waits for the reader to go idle again.
    task automatic run_frame(input logic [16*NW-1:0] f, input bit drop_en);
        int t = 0;
        frame_data_out = f;
        enable = 1'b1;
        fifo_ready = 1'b1;
        while (!frame_pop && t < 50) begin
            @(posedge read_clk); #1;
            t++;
        end
        check("pop_timeout", 32'(t < 50), 32'd1);
        @(posedge read_clk); #1;
        fifo_ready = 1'b0;
        if (drop_en) enable = 1'b0;
        t = 0;
        while (busy && t < 200) begin
            @(posedge read_clk); #1;
            t++;
        end
        check("idle_timeout", 32'(t < 200), 32'd1);
        enable = 1'b1;
    endtask

    initial forever begin
        @(posedge read_clk); #1;
        word_ready = toggle_mode ? ~word_ready : 1'b1;
    end

    // Monitor: pops the scoreboard on each accepted word, checks that a
    // stalled word is held and that frame_pop never lasts two cycles.
    initial begin
        bit          prev_pop = 1'b0;
        bit          prev_stall = 1'b0;
        logic [15:0] pd = '0;
        logic [IW-1:0] pi = '0;
        exp_t        e;
        forever begin
            @(negedge read_clk);
            if (frame_pop) begin
                check("pop_one_cycle", 32'(prev_pop), 32'd0);
                pop_count++;
                pop_cyc_q.push_back(cyc);
            end
            prev_pop = frame_pop;
            if (!reset && word_valid) begin
                if (prev_stall) begin
                    check("stall_data", 32'(word_data), 32'(pd));
                    check("stall_idx", 32'(word_idx), 32'(pi));
                end
                if (word_ready) begin
                    check("word_expected", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("word_data", 32'(word_data), 32'(e.data));
                        check("word_idx", 32'(word_idx), 32'(e.idx));
                        check("word_last", 32'(word_last), 32'(e.last));
                    end
                    if (word_idx == 0) first_hs = cyc;
                    last_hs = cyc;
                end
                prev_stall = !word_ready;
                pd = word_data;
                pi = word_idx;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pop"},    32'(frame_pop), 32'd0);
        check({tag, "_valid"},  32'(word_valid), 32'd0);
        check({tag, "_last"},   32'(word_last), 32'd0);
        check({tag, "_idx"},    32'(word_idx), 32'd0);
        check({tag, "_data"},   32'(word_data), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_frames"}, 32'(frames_read), 32'd0);
    endtask

    initial begin
        logic [15:0]   w[NW];
        logic [16*NW-1:0] f;
        int t;

        repeat (3) @(posedge read_clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // enable low keeps the reader idle despite a ready FIFO
        fifo_ready = 1'b1;
        enable = 1'b0;
        repeat (10) @(posedge read_clk);
        #1;
        check("en_low_pops", 32'(pop_count), 32'd0);
        check("en_low_busy", 32'(busy), 32'd0);
        fifo_ready = 1'b0;

        // reset while word 3 is on the bus
        w = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007};
        push_words(w, 16'h0);
        pack(w, f);
        frame_data_out = f;
        enable = 1'b1;
        fifo_ready = 1'b1;
        t = 0;
        while (!(word_valid && word_idx == 3) && t < 60) begin
            @(posedge read_clk); #1;
            if (busy) fifo_ready = 1'b0;
            t++;
        end
        check("idx3_timeout", 32'(t < 60), 32'd1);
        reset = 1'b1;
        @(posedge read_clk); #1;
        reset = 1'b0;
        check_reset_outputs("midrst");
        q.delete();
        pop_count = 0;

        // all-ones frame, sink always ready, words back to back
        w = '{default: 16'hFFFF};
        push_words(w, 16'hFFF8);
        pack(w, f);
        run_frame(f, 1'b0);
        check("t1_frames", 32'(frames_read), 32'd1);
        check("t1_pops", 32'(pop_count), 32'd1);
        check("t1_consecutive", 32'(last_hs - first_hs), 32'(NWO - 1));
        check("t1_drained", 32'(q.size()), 32'd0);

        // sparse frame; enable dropped mid-frame must not cut it short
        w = '{16'h0, 16'h0, 16'hAAAA, 16'h0, 16'h0, 16'hBBBB, 16'h0, 16'h0};
        push_words(w, 16'h6665);
        pack(w, f);
        run_frame(f, 1'b1);
        check("t2_frames", 32'(frames_read), 32'd2);
        check("t2_drained", 32'(q.size()), 32'd0);

        // sink ready toggling every cycle
        toggle_mode = 1'b1;
        w = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04, 16'h5A05, 16'h5A06, 16'h5A07};
        push_words(w, 16'hD01C);
        pack(w, f);
        run_frame(f, 1'b0);
        toggle_mode = 1'b0;
        check("t3_frames", 32'(frames_read), 32'd3);
        check("t3_drained", 32'(q.size()), 32'd0);

        // fifo_ready held high across three frames
        pop_count = 0;
        pop_cyc_q.delete();
        w = '{default: 16'hFFFF};
        for (int i = 0; i < 3; i++) push_words(w, 16'hFFF8);
        pack(w, f);
        frame_data_out = f;
        fifo_ready = 1'b1;
        t = 0;
        while (frames_read != 16'd6 && t < 300) begin
            @(posedge read_clk); #1;
            t++;
        end
        fifo_ready = 1'b0;
        check("t4_timeout", 32'(t < 300), 32'd1);
        repeat (HO + 4) @(posedge read_clk);
        #1;
        check("t4_pops", 32'(pop_count), 32'd3);
        for (int i = 1; i < pop_cyc_q.size(); i++)
            check("t4_spacing", 32'(pop_cyc_q[i] - pop_cyc_q[i-1] >= NW + HO + 3), 32'd1);
        check("t4_drained", 32'(q.size()), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // checksum vector (plain data check when the sum word is not built)
        w = '{16'h1111, 16'h3333, 16'h7777, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        push_words(w, 16'hBBBB);
        pack(w, f);
        run_frame(f, 1'b0);
        check("t6_frames", 32'(frames_read), 32'd7);
        check("t6_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
